// File: rtl/chunk_serial_add64_pkg.sv
// Shared types and sizing helpers for the chunk-serial 64-bit adder.
// SIGNED_OVF_EN adds a registered signed-overflow flag.
package chunk_serial_add64_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int TOTAL_W_DEF = 64;
    localparam int CHUNK_W_DEF = 16;

    function automatic int nchunk(input int total_w, input int chunk_w);
        return total_w / chunk_w;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_serial_add64_if.sv
// Operand/result handshake bundle for chunk_serial_add64.
// SIGNED_OVF_EN adds the ovf result bit.
interface chunk_serial_add64_if
    import chunk_serial_add64_pkg::*;
#(
    parameter int TOTAL_W = TOTAL_W_DEF
);
    logic               in_valid;
    logic               in_ready;
    logic [TOTAL_W-1:0] a;
    logic [TOTAL_W-1:0] b;
    logic               cin;
    logic               out_valid;
    logic               out_ready;
    logic [TOTAL_W-1:0] sum;
    logic               cout;
    logic               busy;
`ifdef SIGNED_OVF_EN
    logic               ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef SIGNED_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef SIGNED_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/chunk_serial_add64_skip_add16_slice.sv
// Combinational carry-skip adder slice: ripple inside 4-bit blocks,
// block carry bypasses the ripple when every bit propagates.
module skip_add16_slice #(
    parameter int W   = 16,
    parameter int BLK = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o,
    output logic         cout_o
);
    if (W % BLK != 0) begin : g_bad_blk
        $error("skip_add16_slice: W must be a multiple of BLK");
    end

    logic c;
    logic cb;
    logic p;
    logic pall;

    always_comb begin
        s_o  = '0;
        c    = cin_i;
        cb   = 1'b0;
        p    = 1'b0;
        pall = 1'b0;
        for (int k = 0; k < W; k += BLK) begin
            cb   = c;
            pall = 1'b1;
            for (int j = 0; j < BLK; j++) begin
                p          = a_i[k+j] ^ b_i[k+j];
                s_o[k+j]   = p ^ c;
                c          = (a_i[k+j] & b_i[k+j]) | (p & c);
                pall       = pall & p;
            end
            if (pall) c = cb;
        end
        cout_o = c;
    end

endmodule

// File: rtl/chunk_serial_add64.sv
// Multi-cycle wide adder: one CHUNK_W slice, LSB chunk first, carry chained
// through a register. SIGNED_OVF_EN adds a registered signed-overflow output.
module chunk_serial_add64
    import chunk_serial_add64_pkg::*;
#(
    parameter int TOTAL_W = TOTAL_W_DEF,
    parameter int CHUNK_W = CHUNK_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    chunk_serial_add64_if.slave  bus
);
    localparam int NCHUNK = nchunk(TOTAL_W, CHUNK_W);
    localparam int IW     = idx_w(NCHUNK);

    if (TOTAL_W % CHUNK_W != 0) begin : g_bad_width
        $error("chunk_serial_add64: TOTAL_W must be a multiple of CHUNK_W");
    end

    state_e               state_q, state_d;
    logic [TOTAL_W-1:0]   a_q, a_d;
    logic [TOTAL_W-1:0]   b_q, b_d;
    logic [TOTAL_W-1:0]   sum_q, sum_d;
    logic                 carry_q, carry_d;
    logic                 cout_q, cout_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CHUNK_W-1:0]   slice_s;
    logic                 slice_c;
    logic [TOTAL_W-1:0]   slice_ext;

    skip_add16_slice #(.W(CHUNK_W)) u_slice (
        .a_i    (a_q[CHUNK_W-1:0]),
        .b_i    (b_q[CHUNK_W-1:0]),
        .cin_i  (carry_q),
        .s_o    (slice_s),
        .cout_o (slice_c)
    );

    // New chunk enters at the top so the LSB chunk ends up at the bottom.
    assign slice_ext = TOTAL_W'(slice_s);

`ifdef SIGNED_OVF_EN
    logic amsb_q, amsb_d;
    logic bmsb_q, bmsb_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef SIGNED_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef SIGNED_OVF_EN
                    amsb_d  = bus.a[TOTAL_W-1];
                    bmsb_d  = bus.b[TOTAL_W-1];
`endif
                end
            end
            RUN: begin
                sum_d   = (sum_q >> CHUNK_W) | (slice_ext << (TOTAL_W - CHUNK_W));
                carry_d = slice_c;
                a_d     = a_q >> CHUNK_W;
                b_d     = b_q >> CHUNK_W;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(NCHUNK - 1)) begin
                    cout_d  = slice_c;
                    state_d = DONE;
`ifdef SIGNED_OVF_EN
                    ovf_d   = (amsb_q == bmsb_q) &&
                              (slice_s[CHUNK_W-1] != amsb_q);
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

`ifdef SIGNED_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            ovf_q  <= ovf_d;
        end
    end
    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_chunk_serial_add64.sv
// Directed + random bench for chunk_serial_add64 against a plain a+b+cin model.
// SIGNED_OVF_EN also checks the ovf flag.
module tb_chunk_serial_add64;
    import chunk_serial_add64_pkg::*;

    localparam int W = 64;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    chunk_serial_add64_if #(.TOTAL_W(W)) bus ();

    chunk_serial_add64 #(.TOTAL_W(W), .CHUNK_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: accept, count latency, check result, optional
    // backpressure hold, then hand-off.
    task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input int hold, input string tag);
        logic [W:0]   full;
        logic [W-1:0] es;
        logic         ec;
        int           n;
        logic         eo;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        es   = full[W-1:0];
        ec   = full[W];
        eo   = (a[W-1] == b[W-1]) && (es[W-1] != a[W-1]);
        chk({tag, ".in_ready"}, W'(bus.in_ready), W'(1));
        bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
        bus.cin = 1'($urandom);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, W'(n), W'(4));
        chk({tag, ".sum"}, bus.sum, es);
        chk({tag, ".cout"}, W'(bus.cout), W'(ec));
`ifdef SIGNED_OVF_EN
        chk({tag, ".ovf"}, W'(bus.ovf), W'(eo));
`endif
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            chk({tag, ".hold_valid"}, W'(bus.out_valid), W'(1));
            chk({tag, ".hold_sum"}, bus.sum, es);
            chk({tag, ".hold_cout"}, W'(bus.cout), W'(ec));
            chk({tag, ".hold_inrdy"}, W'(bus.in_ready), W'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".post_valid"}, W'(bus.out_valid), W'(0));
        chk({tag, ".post_inrdy"}, W'(bus.in_ready), W'(1));
        chk({tag, ".post_busy"}, W'(bus.busy), W'(0));
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        tick();
        tick();
        chk("rst.out_valid", W'(bus.out_valid), W'(0));
        chk("rst.busy", W'(bus.busy), W'(0));
        chk("rst.in_ready", W'(bus.in_ready), W'(1));
        chk("rst.sum", bus.sum, '0);
        chk("rst.cout", W'(bus.cout), W'(0));
        rst = 1'b0;
        tick();

        txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, "allones_p1");
        txn(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 0, "chain");
        txn(64'd0, 64'd0, 1'b1, 0, "cin_only");
        txn(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, "max_cin");
        txn(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 3, "backpr");
        txn(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, "pos_ovf");
        txn(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, "neg_ovf");

        // Reset during the second RUN cycle discards the operation.
        bus.a = 64'hFFFF_0000_FFFF_0000; bus.b = 64'h0001_0000_0001_0000;
        bus.cin = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", W'(bus.out_valid), W'(0));
        chk("midrst.busy", W'(bus.busy), W'(0));
        chk("midrst.in_ready", W'(bus.in_ready), W'(1));
        chk("midrst.sum", bus.sum, '0);
        tick();
        rst = 1'b0;
        tick();
        txn(64'd5, 64'd7, 1'b0, 0, "after_rst");

        for (int i = 0; i < 20; i++) begin
            txn({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
